// File: rtl/uart_tx_io.sv
// uart_tx_io
//   Memory-mapped UART transmitter on the core's IO page. Stores to UART_DAT
//   queue a byte in a small FIFO; the transmitter drains the FIFO and sends
//   each byte on TXD as an 8N1 frame, LSB first. Loads from UART_CNTL return
//   a status word the core polls before writing.
//
// Ports
//   clk          in   1   system clock, all state on posedge
//   reset        in   1   asynchronous, active-low
//   io_sel       in   1   access targets the IO page
//   io_wstrb     in   1   write strobe
//   io_rstrb     in   1   read strobe
//   io_wordaddr  in   30  one-hot word address: bit1 = UART_DAT, bit2 = UART_CNTL
//   io_wdata     in   32  store data, only [7:0] used
//   io_rdata     out  32  load data, combinational; 0 unless a CNTL read is selected
//   TXD          out  1   serial output, idle high, driven from a register
//   tx_busy      out  1   FIFO non-empty or frame in progress
//   dbg_state    out  2   current transmitter FSM state (debug observation)
//
// Bus handshake: there is no ready/stall. A store is accepted on the edge
// that ends the cycle in which io_sel & io_wstrb & io_wordaddr[1] is high;
// if the FIFO is full before that edge the byte is dropped and the sticky
// overflow flag is set. A CNTL load is answered combinationally in the same
// cycle, and the edge that ends it clears overflow (a new overflow wins).
//
// CNTL status word: bit 10 = overflow, bit 9 = FIFO full, bit 8 = tx_busy.

module uart_tx_io #(
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_AW      = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_sel,
    input  logic        io_wstrb,
    input  logic        io_rstrb,
    input  logic [29:0] io_wordaddr,
    input  logic [31:0] io_wdata,
    output logic [31:0] io_rdata,
    output logic        TXD,
    output logic        tx_busy,
    output logic [1:0]  dbg_state
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LOAD = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic push_req;
    logic cntl_rd;
    logic push;
    logic pop;
    logic ovf_set;

    assign push_req = io_sel & io_wstrb & io_wordaddr[1];
    assign cntl_rd  = io_sel & io_rstrb & io_wordaddr[2];

    // Upper data bits and the other address bits are not decoded here.
    logic unused_bits;
    assign unused_bits = ^{io_wdata[31:8], io_wordaddr[29:3], io_wordaddr[0]};

    // ------------------------------------------------------------------
    // FIFO: pointers carry one extra wrap bit so full and empty are
    // distinguishable without a separate count.
    // ------------------------------------------------------------------
    logic [7:0]       fifo_mem [DEPTH];
    logic [FIFO_AW:0] wr_ptr;
    logic [FIFO_AW:0] rd_ptr;
    logic             fifo_empty;
    logic             fifo_full;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                        (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);

    // Full is judged before the edge, so a same-cycle pop cannot make room.
    assign push    = push_req & ~fifo_full;
    assign ovf_set = push_req & fifo_full;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr[FIFO_AW-1:0]] <= io_wdata[7:0];
    end

    // ------------------------------------------------------------------
    // Sticky overflow flag
    // ------------------------------------------------------------------
    logic overflow;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (ovf_set) begin
            overflow <= 1'b1;
        end else if (cntl_rd) begin
            overflow <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Transmitter FSM
    // ------------------------------------------------------------------
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    idx_q, idx_d;
    logic          txd_q, txd_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            idx_q   <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            txd_q   <= txd_d;
        end
    end

    // txd_d is the line level for the state being entered, so TXD changes
    // on the same edge as the state and comes straight from a flop.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        txd_d   = txd_q;
        pop     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                txd_d = 1'b1;
                cnt_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_mem[rd_ptr[FIFO_AW-1:0]];
                    cnt_d   = CNT_LOAD;
                    state_d = ST_START;
                    txd_d   = 1'b0;
                end
            end

            ST_START: begin
                if (cnt_q == '0) begin
                    cnt_d   = CNT_LOAD;
                    idx_d   = 3'd0;
                    state_d = ST_DATA;
                    txd_d   = shift_q[0];
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            ST_DATA: begin
                if (cnt_q == '0) begin
                    cnt_d   = CNT_LOAD;
                    shift_d = {1'b0, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = ST_STOP;
                        txd_d   = 1'b1;
                    end else begin
                        txd_d = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            ST_STOP: begin
                if (cnt_q == '0) begin
                    if (!fifo_empty) begin
                        // Chain straight into the next start bit: no idle gap.
                        pop     = 1'b1;
                        shift_d = fifo_mem[rd_ptr[FIFO_AW-1:0]];
                        cnt_d   = CNT_LOAD;
                        state_d = ST_START;
                        txd_d   = 1'b0;
                    end else begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                        txd_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                txd_d   = 1'b1;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign TXD       = txd_q;
    assign tx_busy   = (state_q != ST_IDLE) | ~fifo_empty;
    assign dbg_state = state_q;

    always_comb begin
        io_rdata = '0;
        if (cntl_rd) begin
            io_rdata[10] = overflow;
            io_rdata[9]  = fifo_full;
            io_rdata[8]  = tx_busy;
        end
    end

endmodule
